// File: rtl/fsm_state_pkg.sv
// Shared defaults and lock-controller state encodings for the FSM state register.
package fsm_state_pkg;

    localparam int unsigned STATE_W_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 16;

    // Lock controller state encodings; LOCKED doubles as the reset and fall-back state.
    localparam logic [3:0] IDLE     = 4'h0;
    localparam logic [3:0] ARMING   = 4'h1;
    localparam logic [3:0] ACQUIRE  = 4'h2;
    localparam logic [3:0] TRACK    = 4'h3;
    localparam logic [3:0] HOLDOVER = 4'h4;
    localparam logic [3:0] RELOCK   = 4'h5;
    localparam logic [3:0] LOCKED   = 4'hF;

    function automatic logic state_is_legal(input int unsigned code, input int unsigned num_states);
        return code < num_states;
    endfunction

endpackage

// File: rtl/fsm_state_register_dwell.sv
// Saturating dwell counter with synchronous reset, synchronous clear and count enable.
module dwell_counter
    import fsm_state_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over increment; the counter sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fsm_state_register.sv
// FSM state register with previous-state tracking, change pulse, dwell counter and timeout fall-back.
// Optional illegal-encoding trap enabled by defining ILLEGAL_STATE_TRAP_EN.
module fsm_state_register
    import fsm_state_pkg::*;
#(
    parameter int unsigned         STATE_W        = STATE_W_DEF,
    parameter logic [STATE_W-1:0]  RESET_STATE    = STATE_W'(LOCKED),
    parameter logic [STATE_W-1:0]  TIMEOUT_STATE  = STATE_W'(LOCKED),
    parameter int unsigned         TIMEOUT_CYCLES = 0,
    parameter int unsigned         CNT_W          = CNT_W_DEF,
    parameter int unsigned         NUM_STATES     = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Enable,
    input  logic [STATE_W-1:0] Next_State,
    output logic [STATE_W-1:0] Present_State,
    output logic [STATE_W-1:0] Previous_State,
    output logic               State_Changed,
    output logic [CNT_W-1:0]   Dwell_Count,
    output logic               Timeout,
    output logic               Illegal_State
);

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    // Elaboration-time parameter sanity checks.
    if (NUM_STATES == 0 || 64'(NUM_STATES) > (64'(1) << STATE_W)) begin : g_bad_num_states
        $error("fsm_state_register: NUM_STATES out of range");
    end
    if (64'(TIMEOUT_CYCLES) > ((64'(1) << CNT_W) - 64'(1))) begin : g_bad_timeout
        $error("fsm_state_register: TIMEOUT_CYCLES exceeds dwell counter range");
    end

    logic [STATE_W-1:0] state_q,   state_d;
    logic [STATE_W-1:0] prev_q,    prev_d;
    logic               changed_q, changed_d;
    logic               timeout_q, timeout_d;
    logic               illegal_d;
    logic               cnt_clr_c;
    logic               cnt_inc_c;
    logic [CNT_W-1:0]   dwell_c;
    logic               timeout_hit_c;

    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clr_i   (cnt_clr_c),
        .inc_i   (cnt_inc_c),
        .count_o (dwell_c)
    );

    assign timeout_hit_c = TO_EN && (dwell_c == TO_LAST) && (state_q != TIMEOUT_STATE);

    // Next-state selection: illegal trap, requested transition, forced timeout, dwell.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        changed_d = 1'b0;
        timeout_d = 1'b0;
        illegal_d = 1'b0;
        cnt_clr_c = 1'b0;
        cnt_inc_c = 1'b0;
        if (Enable) begin
`ifdef ILLEGAL_STATE_TRAP_EN
            if (!state_is_legal(32'(Next_State), NUM_STATES)) begin
                state_d   = RESET_STATE;
                prev_d    = state_q;
                changed_d = (state_q != RESET_STATE);
                illegal_d = 1'b1;
                cnt_clr_c = 1'b1;
            end else
`endif
            if (Next_State != state_q) begin
                state_d   = Next_State;
                prev_d    = state_q;
                changed_d = 1'b1;
                cnt_clr_c = 1'b1;
            end else if (timeout_hit_c) begin
                state_d   = TIMEOUT_STATE;
                prev_d    = state_q;
                changed_d = 1'b1;
                timeout_d = 1'b1;
                cnt_clr_c = 1'b1;
            end else begin
                cnt_inc_c = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= RESET_STATE;
            prev_q    <= RESET_STATE;
            changed_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            changed_q <= changed_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ILLEGAL_STATE_TRAP_EN
    logic illegal_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign Illegal_State = illegal_q;
`else
    logic unused_illegal;

    assign unused_illegal = illegal_d;
    assign Illegal_State  = 1'b0;
`endif

    assign Present_State  = state_q;
    assign Previous_State = prev_q;
    assign State_Changed  = changed_q;
    assign Dwell_Count    = dwell_c;
    assign Timeout        = timeout_q;

endmodule

// File: tb/tb_fsm_state_register.sv
// Directed bench for fsm_state_register: one timeout-enabled instance and one small saturating-counter instance.
module tb_fsm_state_register;
    import fsm_state_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Instance A: 16-bit dwell, timeout after 5 cycles, 10 legal encodings.
    logic        a_reset, a_en;
    logic [3:0]  a_next, a_ps, a_prev;
    logic        a_chg, a_to, a_ill;
    logic [15:0] a_dw;

    // Instance B: 3-bit dwell, timeout disabled.
    logic        b_reset, b_en;
    logic [3:0]  b_next, b_ps, b_prev;
    logic        b_chg, b_to, b_ill;
    logic [2:0]  b_dw;

    fsm_state_register #(
        .STATE_W(4), .RESET_STATE(4'hF), .TIMEOUT_STATE(4'hF),
        .TIMEOUT_CYCLES(5), .CNT_W(16), .NUM_STATES(10)
    ) u_a (
        .Clk(clk), .Reset(a_reset), .Enable(a_en), .Next_State(a_next),
        .Present_State(a_ps), .Previous_State(a_prev), .State_Changed(a_chg),
        .Dwell_Count(a_dw), .Timeout(a_to), .Illegal_State(a_ill)
    );

    fsm_state_register #(
        .STATE_W(4), .RESET_STATE(4'hF), .TIMEOUT_STATE(4'hF),
        .TIMEOUT_CYCLES(0), .CNT_W(3), .NUM_STATES(16)
    ) u_b (
        .Clk(clk), .Reset(b_reset), .Enable(b_en), .Next_State(b_next),
        .Present_State(b_ps), .Previous_State(b_prev), .State_Changed(b_chg),
        .Dwell_Count(b_dw), .Timeout(b_to), .Illegal_State(b_ill)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic [3:0] ps, input logic [3:0] prev,
                            input logic chg, input logic [15:0] dw, input logic to, input logic ill);
        check({tag, ".ps"},   32'(a_ps),   32'(ps));
        check({tag, ".prev"}, 32'(a_prev), 32'(prev));
        check({tag, ".chg"},  32'(a_chg),  32'(chg));
        check({tag, ".dwell"}, 32'(a_dw),  32'(dw));
        check({tag, ".to"},   32'(a_to),   32'(to));
        check({tag, ".ill"},  32'(a_ill),  32'(ill));
    endtask

    task automatic expect_b(input string tag, input logic [3:0] ps, input logic [3:0] prev,
                            input logic chg, input logic [2:0] dw, input logic to);
        check({tag, ".ps"},   32'(b_ps),   32'(ps));
        check({tag, ".prev"}, 32'(b_prev), 32'(prev));
        check({tag, ".chg"},  32'(b_chg),  32'(chg));
        check({tag, ".dwell"}, 32'(b_dw),  32'(dw));
        check({tag, ".to"},   32'(b_to),   32'(to));
        check({tag, ".ill"},  32'(b_ill),  32'(0));
    endtask

    initial begin
        a_reset = 1'b1; a_en = 1'b0; a_next = 4'h3;
        b_reset = 1'b1; b_en = 1'b0; b_next = 4'h3;

        // Reset for two cycles, second with Enable high.
        step();
        a_en = 1'b1;
        step();
        expect_a("a_reset", 4'hF, 4'hF, 1'b0, 16'd0, 1'b0, 1'b0);
        expect_b("b_reset", 4'hF, 4'hF, 1'b0, 3'd0, 1'b0);

        // Requested transition F -> 2, then dwell counting up to the timeout.
        a_reset = 1'b0; a_next = 4'h2;
        step();
        expect_a("a_enter2", 4'h2, 4'hF, 1'b1, 16'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_a("a_dwell", 4'h2, 4'hF, 1'b0, 16'(i), 1'b0, 1'b0);
        end
        step();
        expect_a("a_timeout", 4'hF, 4'h2, 1'b1, 16'd0, 1'b1, 1'b0);

        // Disabled cycle after the pulse: outputs hold, pulses drop.
        a_en = 1'b0;
        step();
        expect_a("a_dis_hold", 4'hF, 4'h2, 1'b0, 16'd0, 1'b0, 1'b0);

        // Sitting in the timeout state never fires again.
        a_en = 1'b1; a_next = 4'hF;
        step();
        expect_a("a_in_to_state", 4'hF, 4'h2, 1'b0, 16'd1, 1'b0, 1'b0);

        // Enable low for 3 cycles mid-dwell stretches the timeout by 3.
        a_next = 4'h2;
        step();
        expect_a("a_enter2b", 4'h2, 4'hF, 1'b1, 16'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            step();
            expect_a("a_dwell_b", 4'h2, 4'hF, 1'b0, 16'(i), 1'b0, 1'b0);
        end
        a_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_a("a_stretch", 4'h2, 4'hF, 1'b0, 16'd2, 1'b0, 1'b0);
        end
        a_en = 1'b1;
        for (int i = 3; i <= 4; i++) begin
            step();
            expect_a("a_dwell_c", 4'h2, 4'hF, 1'b0, 16'(i), 1'b0, 1'b0);
        end
        step();
        expect_a("a_timeout_b", 4'hF, 4'h2, 1'b1, 16'd0, 1'b1, 1'b0);

        // Requested transition on the timeout edge wins.
        a_next = 4'h2;
        step();
        expect_a("a_enter2c", 4'h2, 4'hF, 1'b1, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("a_pre_race.dwell", 32'(a_dw), 32'd4);
        a_next = 4'h4;
        step();
        expect_a("a_race", 4'h4, 4'h2, 1'b1, 16'd0, 1'b0, 1'b0);

        // Reset one edge before a pending timeout discards it.
        for (int i = 0; i < 4; i++) step();
        check("a_pre_rst.dwell", 32'(a_dw), 32'd4);
        a_reset = 1'b1;
        step();
        expect_a("a_mid_reset", 4'hF, 4'hF, 1'b0, 16'd0, 1'b0, 1'b0);
        a_reset = 1'b0; a_next = 4'hF;
        step();
        expect_a("a_post_reset", 4'hF, 4'hF, 1'b0, 16'd1, 1'b0, 1'b0);

        // Illegal encoding request from state 3, then again from the reset state.
        a_next = 4'h3;
        step();
        expect_a("a_enter3", 4'h3, 4'hF, 1'b1, 16'd0, 1'b0, 1'b0);
        a_next = 4'hC;
        step();
`ifdef ILLEGAL_STATE_TRAP_EN
        expect_a("a_illegal", 4'hF, 4'h3, 1'b1, 16'd0, 1'b0, 1'b1);
        step();
        expect_a("a_illegal_rs", 4'hF, 4'hF, 1'b0, 16'd0, 1'b0, 1'b1);
`else
        expect_a("a_no_trap", 4'hC, 4'h3, 1'b1, 16'd0, 1'b0, 1'b0);
        step();
        expect_a("a_no_trap_hold", 4'hC, 4'h3, 1'b0, 16'd1, 1'b0, 1'b0);
`endif
        a_reset = 1'b1;

        // Instance B: dwell saturates at 7 with timeout disabled, then reset clears it.
        b_reset = 1'b0; b_en = 1'b1; b_next = 4'h5;
        step();
        expect_b("b_enter5", 4'h5, 4'hF, 1'b1, 3'd0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step();
            expect_b("b_sat", 4'h5, 4'hF, 1'b0, (i < 7) ? 3'(i) : 3'd7, 1'b0);
        end
        b_reset = 1'b1;
        step();
        expect_b("b_mid_reset", 4'hF, 4'hF, 1'b0, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
